// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the multicycle adder:
//   - FSM state encoding (IDLE, RUN, DONE)
//   - helpers that derive the number of chunks and the chunk-index width
//     from the WIDTH/CHUNK parameters
// -----------------------------------------------------------------------------
package adder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Number of CHUNK-bit slices in a WIDTH-bit operand.
   function automatic int calc_nchunk(input int width, input int chunk);
      return width / chunk;
   endfunction

   // Width of the chunk index; at least one bit so a single-chunk
   // configuration still has a legal register.
   function automatic int calc_idx_w(input int nchunk);
      return (nchunk <= 1) ? 1 : $clog2(nchunk);
   endfunction

endpackage : adder_pkg

// File: rtl/chunk_adder.sv
// -----------------------------------------------------------------------------
// chunk_adder
// Combinational CHUNK-bit adder slice used once per RUN cycle.
// Ports:
//   x, y : CHUNK-bit addend slices
//   ci   : carry into the slice
//   s    : CHUNK-bit partial sum
//   co   : carry out of the slice
// -----------------------------------------------------------------------------
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};

endmodule : chunk_adder

// File: rtl/multicycle_adder.sv
// -----------------------------------------------------------------------------
// multicycle_adder
// WIDTH-bit adder that processes CHUNK bits per clock, taking
// NCHUNK = WIDTH/CHUNK RUN cycles. WIDTH must be a multiple of CHUNK and
// 1 <= CHUNK <= WIDTH.
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   start    : begin an addition (accepted in IDLE and DONE, ignored in RUN)
//   a, b     : WIDTH-bit addends, captured when start is accepted
//   cin      : carry into bit 0, captured with the operands
//   busy     : high exactly while in RUN
//   done     : high exactly while in DONE (one cycle per result)
//   sum      : result bits, updated on entry to DONE and held
//   carry    : unsigned carry out of bit WIDTH-1
//   overflow : two's complement overflow
// -----------------------------------------------------------------------------
module multicycle_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int            NCHUNK   = calc_nchunk(WIDTH, CHUNK);
   localparam int            IW       = calc_idx_w(NCHUNK);
   localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] psum_q, psum_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             cy_q, cy_d;        // running carry between chunks
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;

   logic [CHUNK-1:0] x_chunk, y_chunk, s_chunk;
   logic             co_chunk;
   logic [WIDTH-1:0] psum_upd;
   logic             accept;

   // Start is only honoured when no addition is in flight.
   assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   // Chunk selection and partial-sum merge are written as a constant-index
   // mux so each slice is a fixed wire range rather than a barrel shifter.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      x_chunk  = '0;
      y_chunk  = '0;
      psum_upd = psum_q;
      for (int i = 0; i < NCHUNK; i++) begin
         if (idx_q == IW'(i)) begin
            x_chunk                      = a_q[i*CHUNK +: CHUNK];
            y_chunk                      = b_q[i*CHUNK +: CHUNK];
            psum_upd[i*CHUNK +: CHUNK]   = s_chunk;
         end
      end
   end

   chunk_adder #(
      .CHUNK(CHUNK)
   ) u_chunk_adder (
      .x  (x_chunk),
      .y  (y_chunk),
      .ci (cy_q),
      .s  (s_chunk),
      .co (co_chunk)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      psum_d  = psum_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      cy_d    = cy_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_RUN;
         end
         ST_RUN: begin
            psum_d = psum_upd;
            cy_d   = co_chunk;
            idx_d  = idx_q + IW'(1);
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
               idx_d   = '0;
               sum_d   = psum_upd;
               carry_d = co_chunk;
               // Carry into the MSB is recovered from the MSB sum bit:
               // c_in = a ^ b ^ s at that position.
               ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ psum_upd[WIDTH-1] ^ co_chunk;
            end
         end
         ST_DONE: begin
            state_d = start ? ST_RUN : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Capture overrides the per-state updates on the accepting edge.
      if (accept) begin
         a_d    = a;
         b_d    = b;
         cy_d   = cin;
         idx_d  = '0;
         psum_d = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         psum_q  <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         cy_q    <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         psum_q  <= psum_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         cy_q    <= cy_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy     = (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE);
   assign sum      = sum_q;
   assign carry    = carry_q;
   assign overflow = ovf_q;

endmodule : multicycle_adder

// File: tb/tb_multicycle_adder.sv
// -----------------------------------------------------------------------------
// tb_multicycle_adder
// Directed self-checking bench. Three configurations share clk/rst_n:
//   u_dut16 : WIDTH=16, CHUNK=4 (latency, hazards, reset abort)
//   u_dut8d : WIDTH=8,  CHUNK=8 (single-chunk degenerate case)
//   gen_x[] : 16 copies of WIDTH=8, CHUNK=4 sweeping every operand pair,
//             copy j owning the operands whose upper nibble equals j.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_multicycle_adder;

   logic clk;
   logic rst_n;

   int n_checks;
   int n_fail;

   // WIDTH=16, CHUNK=4
   logic        start16, cin16, busy16, done16, carry16, ovf16;
   logic [15:0] a16, b16, sum16;

   // WIDTH=8, CHUNK=8
   logic        startd, cind, busyd, doned, carryd, ovfd;
   logic [7:0]  ad, bd, sumd;

   // WIDTH=8, CHUNK=4 sweep array
   logic        x_start, x_cin;
   logic [7:0]  x_a   [16];
   logic [7:0]  x_b   [16];
   logic [7:0]  x_sum [16];
   logic        x_busy  [16];
   logic        x_done  [16];
   logic        x_carry [16];
   logic        x_ovf   [16];

   multicycle_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
      .busy(busy16), .done(done16), .sum(sum16), .carry(carry16), .overflow(ovf16)
   );

   multicycle_adder #(.WIDTH(8), .CHUNK(8)) u_dut8d (
      .clk(clk), .rst_n(rst_n), .start(startd), .a(ad), .b(bd), .cin(cind),
      .busy(busyd), .done(doned), .sum(sumd), .carry(carryd), .overflow(ovfd)
   );

   for (genvar g = 0; g < 16; g++) begin : gen_x
      multicycle_adder #(.WIDTH(8), .CHUNK(4)) u_dut8 (
         .clk(clk), .rst_n(rst_n), .start(x_start), .a(x_a[g]), .b(x_b[g]), .cin(x_cin),
         .busy(x_busy[g]), .done(x_done[g]), .sum(x_sum[g]), .carry(x_carry[g]),
         .overflow(x_ovf[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Pulse start on the 16-bit DUT and wait (bounded) for done.
   // lat counts edges from the accepting edge to the one entering DONE.
   task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        output int lat, output int busy_cnt);
      a16     = av;
      b16     = bv;
      cin16   = cv;
      start16 = 1'b1;
      tick();
      start16  = 1'b0;
      lat      = 1;
      busy_cnt = busy16 ? 1 : 0;
      while (!done16 && lat < 20) begin
         tick();
         lat++;
         if (busy16) busy_cnt++;
      end
   endtask

   initial begin
      int lat, lat2, bc, seen;
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
      startd  = 1'b0; ad  = '0; bd  = '0; cind  = 1'b0;
      x_start = 1'b0; x_cin = 1'b0;
      for (int j = 0; j < 16; j++) begin
         x_a[j] = '0;
         x_b[j] = '0;
      end

      // Reset state, with the clock running.
      #23;
      check("rst_busy", busy16, 0);
      check("rst_done", done16, 0);
      check("rst_sum", sum16, 0);
      check("rst_carry_ovf", {carry16, ovf16}, 0);
      tick();
      rst_n = 1'b1;

      // 0xFFFF + 0x0001: wrap to zero with carry.
      run16(16'hFFFF, 16'h0001, 1'b0, lat, bc);
      check("wrap_latency", lat, 5);
      check("wrap_busy_cycles", bc, 4);
      check("wrap_sum", sum16, 16'h0000);
      check("wrap_carry", carry16, 1);
      check("wrap_ovf", ovf16, 0);
      tick();
      check("done_one_cycle", done16, 0);

      // Signed overflow cases.
      run16(16'h7FFF, 16'h0001, 1'b0, lat, bc);
      check("pos_ovf_sum", sum16, 16'h8000);
      check("pos_ovf_cy_ov", {carry16, ovf16}, 2'b01);
      tick();
      run16(16'h8000, 16'h8000, 1'b0, lat, bc);
      check("neg_ovf_sum", sum16, 16'h0000);
      check("neg_ovf_cy_ov", {carry16, ovf16}, 2'b11);
      tick();

      // Start re-pulsed two cycles into RUN with other operands: ignored.
      a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      tick();
      a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      lat = 3;
      while (!done16 && lat < 20) begin
         tick();
         lat++;
      end
      check("ign_latency", lat, 5);
      check("ign_sum", sum16, 16'h2345);
      check("ign_cy_ov", {carry16, ovf16}, 2'b00);
      tick();
      check("ign_no_restart", {busy16, done16}, 2'b00);

      // Start held high through DONE: back-to-back, operands changed
      // while RUN must not disturb the first result.
      a16 = 16'h0F0F; b16 = 16'h00F1; cin16 = 1'b1; start16 = 1'b1;
      tick();
      a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
      lat = 1;
      while (!done16 && lat < 20) begin
         tick();
         lat++;
      end
      check("b2b_first_latency", lat, 5);
      check("b2b_first_sum", sum16, 16'h1001);
      check("b2b_first_cy_ov", {carry16, ovf16}, 2'b00);
      tick();
      lat2 = 1;
      check("b2b_no_gap_busy", busy16, 1);
      while (!done16 && lat2 < 20) begin
         tick();
         lat2++;
      end
      check("b2b_second_gap", lat2, 5);
      check("b2b_second_sum", sum16, 16'hFFFF);
      check("b2b_second_cy_ov", {carry16, ovf16}, 2'b10);
      start16 = 1'b0;
      tick();
      check("b2b_back_idle", {busy16, done16}, 2'b00);

      // Reset asserted during RUN cycle 2 aborts the operation.
      a16 = 16'h00FF; b16 = 16'h0001; cin16 = 1'b0; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy16, 0);
      check("abort_done", done16, 0);
      check("abort_sum", sum16, 0);
      check("abort_carry", carry16, 0);
      seen = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (done16 || busy16) seen++;
      end
      check("abort_quiet_in_reset", seen, 0);
      rst_n = 1'b1;
      // Start presented immediately after release is taken on the first edge.
      a16 = 16'h1234; b16 = 16'h4321; cin16 = 1'b0; start16 = 1'b1;
      tick();
      start16 = 1'b0;
      check("post_rst_accept", {busy16, done16}, 2'b10);
      lat = 1;
      while (!done16 && lat < 20) begin
         tick();
         lat++;
      end
      check("post_rst_latency", lat, 5);
      check("post_rst_sum", sum16, 16'h5555);
      tick();

      // Single-chunk configuration: 0xAA + 0x55 + 1.
      ad = 8'hAA; bd = 8'h55; cind = 1'b1; startd = 1'b1;
      tick();
      startd = 1'b0;
      lat = 1;
      bc  = busyd ? 1 : 0;
      while (!doned && lat < 20) begin
         tick();
         lat++;
         if (busyd) bc++;
      end
      check("deg_latency", lat, 2);
      check("deg_busy_cycles", bc, 1);
      check("deg_sum", sumd, 8'h00);
      check("deg_cy_ov", {carryd, ovfd}, 2'b10);

      // Exhaustive WIDTH=8/CHUNK=4 sweep; each new start is accepted in DONE.
      for (int alo = 0; alo < 16; alo++) begin
         for (int bv = 0; bv < 256; bv++) begin
            for (int c = 0; c < 2; c++) begin
               for (int j = 0; j < 16; j++) begin
                  x_a[j] = 8'(j * 16 + alo);
                  x_b[j] = 8'(bv);
               end
               x_cin   = c[0];
               x_start = 1'b1;
               tick();
               x_start = 1'b0;
               tick();
               tick();
               for (int j = 0; j < 16; j++) begin
                  int av, sa, sb, sv, uv;
                  logic exp_ovf;
                  av      = j * 16 + alo;
                  uv      = av + bv + c;
                  sa      = (av >= 128) ? av - 256 : av;
                  sb      = (bv >= 128) ? bv - 256 : bv;
                  sv      = sa + sb + c;
                  exp_ovf = (sv > 127) || (sv < -128);
                  check("exh_done_ovf_cy_sum",
                        {21'd0, x_done[j], x_ovf[j], x_carry[j], x_sum[j]},
                        {21'd0, 1'b1, exp_ovf, 9'(uv)});
               end
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_multicycle_adder

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, meaning bits added per clock cycle; WIDTH % CHUNK == 0 and 1 <= CHUNK <= WIDTH.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock; the block has one clock.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port start  input  1  request to begin an addition.
REQ-006 The block SHALL have port a  input  WIDTH  addend A, unsigned or two's complement.
REQ-007 The block SHALL have port b  input  WIDTH  addend B.
REQ-008 The block SHALL have port cin  input  1  carry into bit 0.
REQ-009 The block SHALL have port busy  output  1  high while an addition is in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-011 The block SHALL have port sum  output  WIDTH  result bits.
REQ-012 The block SHALL have port carry  output  1  unsigned carry out of bit WIDTH-1.
REQ-013 The block SHALL have port overflow  output  1  signed (two's complement) overflow.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE. IDLE goes to RUN on start. RUN goes to DONE after NCHUNK = WIDTH/CHUNK cycles. DONE goes to RUN if start is high, else to IDLE.
REQ-015 On the edge that accepts start, a, b and cin SHALL be captured into internal registers, the chunk index SHALL be set to 0, and the running carry SHALL be set to cin.
REQ-016 Each RUN cycle SHALL add chunk i (bits i*CHUNK+CHUNK-1 : i*CHUNK) of the captured operands plus the running carry, store the CHUNK-bit partial sum, update the running carry, and increment i.
REQ-017 sum, carry and overflow SHALL update together on the edge entering DONE and SHALL hold their values until the next entry into DONE.
REQ-018 overflow SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-019 done SHALL be high exactly during the DONE state; a start sampled high in cycle k SHALL make done high in cycle k+NCHUNK+1.
REQ-020 busy SHALL be high exactly during the RUN state.
REQ-021 start while in RUN SHALL be ignored, with no capture and no effect on the operation in flight.
REQ-022 start while in DONE SHALL be accepted, giving back-to-back operation with no idle gap; a, b and cin changing while not accepting SHALL have no effect.
REQ-023 For CHUNK == WIDTH, RUN SHALL last one cycle and the latency SHALL be 2 cycles.
REQ-024 Full-width wrap-around SHALL be modulo 2^WIDTH, with the excess reported only on carry.

Reset
REQ-025 While rst_n is low, the state SHALL be IDLE, busy=0, done=0, sum=0, carry=0 and overflow=0, with all internal registers cleared, regardless of clk.
REQ-026 Assertion of rst_n mid-RUN SHALL abort the operation, with no done pulse and no change to sum beyond clearing it.
REQ-027 After rst_n deasserts, start SHALL be accepted on the first rising edge.

Structure
REQ-028 Shared package adder_pkg SHALL hold the state encoding (IDLE, RUN, DONE) and the helper that computes NCHUNK and the chunk-index width.
REQ-029 The per-cycle addition SHALL be one combinational sub-module chunk_adder, with parameter CHUNK, inputs x, y and ci, and outputs s and co.
REQ-030 The index counter, the operand registers and the FSM SHALL reside in multicycle_adder.

Verification
REQ-031 The bench SHALL check, with WIDTH=16 and CHUNK=4: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, carry=1, overflow=0, done 5 cycles after start, busy high 4 cycles.
REQ-032 The bench SHALL check: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, carry=0, overflow=1; then a=0x8000, b=0x8000 -> sum=0x0000, carry=1, overflow=1.
REQ-033 The bench SHALL check: start pulsed again 2 cycles into RUN with different operands -> ignored, first result unchanged; start held high through DONE -> second result 5 cycles after the first.
REQ-034 The bench SHALL check: rst_n pulled low during RUN cycle 2 -> busy=0, done never pulses, and sum=0 after reset.
REQ-035 The bench SHALL check exhaustively, with WIDTH=8 and CHUNK=4, all 256x256 operand pairs x cin 0/1 -> {carry,sum} == a+b+cin and overflow matches the signed reference.
REQ-036 The bench SHALL check the degenerate case WIDTH=8, CHUNK=8: a=0xAA, b=0x55, cin=1 -> sum=0x00, carry=1, done 2 cycles after start.
